// File: rtl/branch_pc_fetch_pkg.sv
// rtl/branch_pc_fetch_pkg.sv - shared state encoding and constants for the PC/fetch stage
//   Contents: state_t (FETCH_REQ, FETCH, ISSUE, RESOLVE, TRAP), BR_OPCODE_DEF, PC_STEP, RESET_PC_DEF
package branch_pc_fetch_pkg;

  typedef enum logic [2:0] {
    ST_FETCH_REQ = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_RESOLVE   = 3'd3,
    ST_TRAP      = 3'd4
  } state_t;

  localparam logic [6:0]  BR_OPCODE_DEF = 7'h63;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

endpackage

// File: rtl/branch_pc_fetch_if.sv
// rtl/branch_pc_fetch_if.sv - fetch-stage bus: imem req/ack, decode valid/ready, branch result
//   master: fetch stage side (drives o*, samples i*)
//   slave : environment side (imem, decode, branch unit)
interface branch_pc_fetch_if;

  logic        oIMEM_REQ;
  logic [31:0] oIMEM_ADDR;
  logic        iIMEM_ACK;
  logic [31:0] iIMEM_DATA;
  logic [31:0] oIR;
  logic [31:0] oPC;
  logic        oIR_VALID;
  logic        iIR_READY;
  logic        iBR_VALID;
  logic [31:0] iPCBR;
  logic        oERR;

  modport master (
    output oIMEM_REQ, oIMEM_ADDR, oIR, oPC, oIR_VALID, oERR,
    input  iIMEM_ACK, iIMEM_DATA, iIR_READY, iBR_VALID, iPCBR
  );

  modport slave (
    input  oIMEM_REQ, oIMEM_ADDR, oIR, oPC, oIR_VALID, oERR,
    output iIMEM_ACK, iIMEM_DATA, iIR_READY, iBR_VALID, iPCBR
  );

endinterface

// File: rtl/branch_pc_fetch_pc_next_calc.sv
// rtl/branch_pc_fetch_pc_next_calc.sv - next-PC arithmetic: PC+offset, or PC+4 when offset is 0
//   i_pc         : current PC
//   i_offset     : signed byte offset, 0 means fall through
//   o_target     : next PC (32-bit modulo)
//   o_misaligned : target not word aligned
module pc_next_calc
  import branch_pc_fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [31:0] i_offset,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  // Two's complement add covers negative offsets and wrap past 32'hFFFF_FFFC.
  assign o_target     = (i_offset != 32'd0) ? (i_pc + i_offset) : (i_pc + PC_STEP);
  assign o_misaligned = |o_target[1:0];

endmodule

// File: rtl/branch_pc_fetch.sv
// rtl/branch_pc_fetch.sv - program counter and instruction fetch ahead of the branch unit
//   iCLK : clock, posedge
//   iRST : synchronous active-high reset
//   bus  : master side of branch_pc_fetch_if (imem req/ack, decode valid/ready, branch offset, sticky error)
module branch_pc_fetch
  import branch_pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
  parameter logic [6:0]  BR_OPCODE   = BR_OPCODE_DEF,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  branch_pc_fetch_if.master bus
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(ACK_TIMEOUT);

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_err;
  logic [7:0]  r_cnt;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_ir_nxt;
  logic        w_err_nxt;
  logic [7:0]  w_cnt_nxt;
  logic [7:0]  w_cnt_inc;
  logic [31:0] w_offset;
  logic [31:0] w_target;
  logic        w_misaligned;

  // Outside RESOLVE the calculator is fed a zero offset, so it yields PC+4.
  assign w_offset  = (r_state == ST_RESOLVE) ? bus.iPCBR : 32'd0;
  assign w_cnt_inc = r_cnt + 8'd1;

  pc_next_calc u_pc_next_calc (
    .i_pc         (r_pc),
    .i_offset     (w_offset),
    .o_target     (w_target),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ST_FETCH_REQ;
      r_pc    <= RESET_PC;
      r_ir    <= 32'd0;
      r_err   <= 1'b0;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_ir    <= w_ir_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_nxt    = r_ir;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_FETCH_REQ: begin
        // Idle cycle with REQ low; the timeout count restarts for the new fetch.
        w_cnt_nxt   = 8'd0;
        w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.iIMEM_ACK) begin
          w_ir_nxt    = bus.iIMEM_DATA;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == TIMEOUT_CNT) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_TRAP;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.iIR_READY) begin
          if (r_ir[6:0] == BR_OPCODE) begin
            w_state_nxt = ST_RESOLVE;
          end else begin
            w_pc_nxt    = w_target;
            w_state_nxt = ST_FETCH_REQ;
          end
        end
      end
      ST_RESOLVE: begin
        if (bus.iBR_VALID) begin
          if (w_misaligned) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_TRAP;
          end else begin
            w_pc_nxt    = w_target;
            w_state_nxt = ST_FETCH_REQ;
          end
        end
      end
      ST_TRAP: begin
        w_state_nxt = ST_TRAP;
      end
      default: begin
        w_state_nxt = ST_TRAP;
      end
    endcase
  end

  assign bus.oIMEM_REQ  = (r_state == ST_FETCH);
  assign bus.oIMEM_ADDR = r_pc;
  assign bus.oPC        = r_pc;
  assign bus.oIR        = r_ir;
  assign bus.oIR_VALID  = (r_state == ST_ISSUE);
  assign bus.oERR       = r_err;

endmodule

// File: tb/tb_branch_pc_fetch.sv
// tb/tb_branch_pc_fetch.sv - self-checking bench for branch_pc_fetch with a behavioural model
module tb_branch_pc_fetch;

  localparam logic [31:0] BR_WORD  = 32'h0020_8463;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam int          TMO      = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  branch_pc_fetch_if bus ();
  branch_pc_fetch_if bus2 ();

  branch_pc_fetch #(.RESET_PC(32'h0000_0000), .BR_OPCODE(7'h63), .ACK_TIMEOUT(TMO)) dut (
    .iCLK(clk), .iRST(rst), .bus(bus)
  );

  branch_pc_fetch #(.RESET_PC(32'hFFFF_FFFC), .BR_OPCODE(7'h63), .ACK_TIMEOUT(TMO)) dut2 (
    .iCLK(clk), .iRST(rst), .bus(bus2)
  );

  // Model: where the instruction stream stands, described by what is pending.
  typedef struct packed {
    logic        live;
    logic        dead;   // trapped, waiting for reset
    logic        gap;    // one quiet cycle before the next request
    logic        hold;   // instruction offered to decode
    logic        br;     // waiting for the branch unit
    logic [31:0] pc;
    logic [31:0] ir;
    logic        err;
    int          waited; // request cycles without ack
  } mdl_t;

  mdl_t m = '0;

  function automatic mdl_t mdl_next(mdl_t s, logic r, logic ack, logic [31:0] data,
                                    logic rdy, logic bv, logic [31:0] pcbr);
    mdl_t n = s;
    logic [31:0] tgt;
    if (r) begin
      n = '0;
      n.live = 1'b1;
      n.gap  = 1'b1;
      n.pc   = 32'h0000_0000;
    end else if (s.live && !s.dead) begin
      if (s.gap) begin
        n.gap    = 1'b0;
        n.waited = 0;
      end else if (s.hold) begin
        if (rdy) begin
          n.hold = 1'b0;
          if (s.ir[6:0] == 7'h63) n.br = 1'b1;
          else begin
            n.pc  = s.pc + 32'd4;
            n.gap = 1'b1;
          end
        end
      end else if (s.br) begin
        if (bv) begin
          tgt  = (pcbr != 32'd0) ? s.pc + pcbr : s.pc + 32'd4;
          n.br = 1'b0;
          if (tgt[1:0] != 2'b00) begin
            n.err  = 1'b1;
            n.dead = 1'b1;
          end else begin
            n.pc  = tgt;
            n.gap = 1'b1;
          end
        end
      end else begin
        if (ack) begin
          n.ir   = data;
          n.hold = 1'b1;
        end else begin
          n.waited = s.waited + 1;
          if (n.waited == TMO) begin
            n.err  = 1'b1;
            n.dead = 1'b1;
          end
        end
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= mdl_next(m, rst, bus.iIMEM_ACK, bus.iIMEM_DATA, bus.iIR_READY, bus.iBR_VALID, bus.iPCBR);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (m.live) begin
      chk("mdl_req",   32'(bus.oIMEM_REQ), 32'(!m.dead && !m.gap && !m.hold && !m.br));
      chk("mdl_valid", 32'(bus.oIR_VALID), 32'(m.hold && !m.dead));
      chk("mdl_err",   32'(bus.oERR), 32'(m.err));
      chk("mdl_pc",    bus.oPC, m.pc);
      chk("mdl_addr",  bus.oIMEM_ADDR, m.pc);
      chk("mdl_ir",    bus.oIR, m.ir);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic serve(input logic [31:0] w);
    int n = 0;
    while (!bus.oIMEM_REQ && n < 50) begin
      tick();
      n++;
    end
    chk("serve_req_seen", 32'(bus.oIMEM_REQ), 32'd1);
    bus.iIMEM_DATA = w;
    bus.iIMEM_ACK  = 1'b1;
    tick();
    bus.iIMEM_ACK  = 1'b0;
  endtask

  task automatic do_branch(input logic [31:0] off, input logic [31:0] exp_pc);
    serve(BR_WORD);
    tick();
    bus.iBR_VALID = 1'b1;
    bus.iPCBR     = off;
    tick();
    bus.iBR_VALID = 1'b0;
    chk("br_gap_req", 32'(bus.oIMEM_REQ), 32'd0);
    tick();
    chk("br_req", 32'(bus.oIMEM_REQ), 32'd1);
    chk("br_addr", bus.oIMEM_ADDR, exp_pc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] tmp;
    int          stall;
    int          cnt;
    rst = 1'b1;
    bus.iIMEM_ACK = 1'b0;  bus.iIMEM_DATA = '0; bus.iIR_READY = 1'b1;
    bus.iBR_VALID = 1'b0;  bus.iPCBR = '0;
    bus2.iIMEM_ACK = 1'b0; bus2.iIMEM_DATA = '0; bus2.iIR_READY = 1'b1;
    bus2.iBR_VALID = 1'b0; bus2.iPCBR = '0;
    tick();
    tick();
    chk("rst_pc", bus.oPC, 32'h0);
    chk("rst_req", 32'(bus.oIMEM_REQ), 32'd0);
    chk("rst_valid", 32'(bus.oIR_VALID), 32'd0);
    chk("rst_err", 32'(bus.oERR), 32'd0);
    chk("rst_ir", bus.oIR, 32'h0);
    chk("rst_pc2", bus2.oPC, 32'hFFFF_FFFC);

    // First fetch: ack after two request cycles.
    rst = 1'b0;
    tick();
    chk("first_req", 32'(bus.oIMEM_REQ), 32'd1);
    chk("first_addr", bus.oIMEM_ADDR, 32'h0);
    tick();
    bus.iIMEM_ACK = 1'b1; bus.iIMEM_DATA = NOP_WORD;
    tick();
    bus.iIMEM_ACK = 1'b0;
    chk("ack_valid", 32'(bus.oIR_VALID), 32'd1);
    chk("ack_ir", bus.oIR, NOP_WORD);
    chk("ack_req", 32'(bus.oIMEM_REQ), 32'd0);
    tick();
    chk("hs_valid", 32'(bus.oIR_VALID), 32'd0);
    chk("hs_pc", bus.oPC, 32'h4);
    tick();
    chk("next_req", 32'(bus.oIMEM_REQ), 32'd1);
    chk("next_addr", bus.oIMEM_ADDR, 32'h4);

    // Spurious branch results during fetch and issue.
    bus.iBR_VALID = 1'b1; bus.iPCBR = 32'h40;
    serve(NOP_WORD);
    chk("spur_pc_issue", bus.oPC, 32'h4);
    tick();
    chk("spur_pc_next", bus.oPC, 32'h8);
    bus.iBR_VALID = 1'b0;
    serve(NOP_WORD);
    serve(NOP_WORD);

    // Branches resolved at 0x10 and its neighbours.
    do_branch(32'h8, 32'h18);
    do_branch(32'hFFFF_FFF8, 32'h10);
    do_branch(32'h0, 32'h14);
    do_branch(32'hFFFF_FFFC, 32'h10);
    do_branch(32'hFFFF_FFF0, 32'h0);

    // Decode back-pressure.
    bus.iIR_READY = 1'b0;
    serve(NOP_WORD);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", 32'(bus.oIR_VALID), 32'd1);
      chk("hold_ir", bus.oIR, NOP_WORD);
      chk("hold_pc", bus.oPC, 32'h0);
      chk("hold_req", 32'(bus.oIMEM_REQ), 32'd0);
      tick();
    end
    bus.iIR_READY = 1'b1;
    tick();
    chk("rel_gap", 32'(bus.oIMEM_REQ), 32'd0);
    tick();
    chk("rel_req", 32'(bus.oIMEM_REQ), 32'd1);
    chk("rel_addr", bus.oIMEM_ADDR, 32'h4);

    // Misaligned branch target at 0x20.
    serve(NOP_WORD);
    do_branch(32'h18, 32'h20);
    serve(BR_WORD);
    tick();
    bus.iBR_VALID = 1'b1; bus.iPCBR = 32'h6;
    tick();
    bus.iBR_VALID = 1'b0;
    chk("mis_err", 32'(bus.oERR), 32'd1);
    chk("mis_pc", bus.oPC, 32'h20);
    bus.iIMEM_ACK = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("trap_req", 32'(bus.oIMEM_REQ), 32'd0);
      chk("trap_valid", 32'(bus.oIR_VALID), 32'd0);
    end
    bus.iIMEM_ACK = 1'b0;

    // Fetch timeout.
    rst = 1'b1;
    tick();
    chk("tmo_rst_err", 32'(bus.oERR), 32'd0);
    rst = 1'b0;
    tick();
    cnt = 0;
    while (bus.oIMEM_REQ && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("tmo_cycles", 32'(cnt), 32'd16);
    chk("tmo_err", 32'(bus.oERR), 32'd1);
    bus.iIMEM_ACK = 1'b1;
    tick();
    bus.iIMEM_ACK = 1'b0;
    chk("tmo_late_ack_req", 32'(bus.oIMEM_REQ), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("recover_err", 32'(bus.oERR), 32'd0);
    chk("recover_req", 32'(bus.oIMEM_REQ), 32'd1);
    chk("recover_addr", bus.oIMEM_ADDR, 32'h0);

    // Reset while fetching, with an ack arriving right after.
    rst = 1'b1;
    tick();
    chk("midrst_req", 32'(bus.oIMEM_REQ), 32'd0);
    rst = 1'b0;
    bus.iIMEM_ACK = 1'b1; bus.iIMEM_DATA = NOP_WORD;
    tick();
    bus.iIMEM_ACK = 1'b0;
    chk("midrst_req2", 32'(bus.oIMEM_REQ), 32'd1);
    chk("midrst_valid", 32'(bus.oIR_VALID), 32'd0);
    tick();
    chk("midrst_valid2", 32'(bus.oIR_VALID), 32'd0);

    // PC wrap on the second instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("wrap_req", 32'(bus2.oIMEM_REQ), 32'd1);
    chk("wrap_addr", bus2.oIMEM_ADDR, 32'hFFFF_FFFC);
    bus2.iIMEM_ACK = 1'b1; bus2.iIMEM_DATA = NOP_WORD;
    tick();
    bus2.iIMEM_ACK = 1'b0;
    chk("wrap_valid", 32'(bus2.oIR_VALID), 32'd1);
    tick();
    tick();
    chk("wrap_req2", 32'(bus2.oIMEM_REQ), 32'd1);
    chk("wrap_addr2", bus2.oIMEM_ADDR, 32'h0);

    // Randomized traffic against the model.
    stall = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      if (stall > 0) begin
        bus.iIMEM_ACK = 1'b0;
        stall--;
      end else begin
        bus.iIMEM_ACK = ($urandom_range(0, 2) == 0);
      end
      if ($urandom_range(0, 150) == 0) stall = 20;
      tmp = $urandom();
      bus.iIMEM_DATA = ($urandom_range(0, 1) == 1) ? BR_WORD : {tmp[31:7], 7'h13};
      bus.iIR_READY  = ($urandom_range(0, 3) != 0);
      bus.iBR_VALID  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 9))
        0:       bus.iPCBR = 32'h0;
        1:       bus.iPCBR = 32'h6;
        2:       bus.iPCBR = 32'h2;
        default: bus.iPCBR = (32'($urandom_range(0, 31)) - 32'd16) << 2;
      endcase
      cnt = m.dead ? cnt + 1 : 0;
      rst = (cnt > 3) || ($urandom_range(0, 199) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
